// File: rtl/ysyx_22050243_inst_encoder.sv
// Instruction encoder: packs format/opcode/register/funct/immediate fields into a
// 32-bit RV64 instruction word. The immediate is range-checked so that the
// immediate generator's decode of the emitted word returns the supplied value.
// Results are buffered in a 2-entry FIFO with valid/ready on both sides.
module ysyx_22050243_inst_encoder #(
  parameter int IBUS_DATA_WIDTH = 32,
  parameter int DBUS_DATA_WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_fmt,
  input  logic [6:0]                 in_opcode,
  input  logic [4:0]                 in_rd,
  input  logic [4:0]                 in_rs1,
  input  logic [4:0]                 in_rs2,
  input  logic [2:0]                 in_funct3,
  input  logic [6:0]                 in_funct7,
  input  logic [DBUS_DATA_WIDTH-1:0] in_imm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IBUS_DATA_WIDTH-1:0] out_inst,
  output logic                       out_err,
  output logic [15:0]                err_cnt
);

  localparam int DW = DBUS_DATA_WIDTH;

  logic [31:0] enc_inst;
  logic        enc_err;

  // Upper immediate bits must be a pure sign extension of the encodable field.
  logic fits12, fits13, fits20, fits21;
  assign fits12 = (&in_imm[DW-1:11]) | ~(|in_imm[DW-1:11]);
  assign fits13 = (&in_imm[DW-1:12]) | ~(|in_imm[DW-1:12]);
  assign fits20 = (&in_imm[DW-1:19]) | ~(|in_imm[DW-1:19]);
  assign fits21 = (&in_imm[DW-1:20]) | ~(|in_imm[DW-1:20]);

  // Field packing and error detection; out-of-range immediates still encode truncated bits.
  always_comb begin
    enc_inst = '0;
    enc_err  = 1'b0;
    case (in_fmt)
      3'd0: enc_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      3'd1: begin
        enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        enc_err  = ~fits12;
      end
      3'd2: begin
        enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        enc_err  = ~fits12;
      end
      3'd3: begin
        enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
        enc_err  = ~fits13 | in_imm[0];
      end
      3'd4: begin
        enc_inst = {in_imm[19:0], in_rd, in_opcode};
        enc_err  = ~fits20;
      end
      3'd5: begin
        enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        enc_err  = ~fits21 | in_imm[0];
      end
      default: begin
        enc_inst = '0;
        enc_err  = 1'b1;
      end
    endcase
  end

  logic [IBUS_DATA_WIDTH-1:0] mem_inst [2];
  logic                       mem_err  [2];
  logic                       wr_ptr, rd_ptr;
  logic [1:0]                 count, count_nxt;
  logic                       push, pop;

  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_inst  = out_valid ? mem_inst[rd_ptr] : '0;
  assign out_err   = out_valid ? mem_err[rd_ptr]  : 1'b0;

  // Occupancy after this edge; push+pop together leaves it unchanged.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  // FIFO storage, pointers and a registered in_ready (no path from out_ready).
  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= 2'd0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      in_ready    <= 1'b1;
      mem_inst[0] <= '0;
      mem_inst[1] <= '0;
      mem_err[0]  <= 1'b0;
      mem_err[1]  <= 1'b0;
    end else begin
      if (push) begin
        mem_inst[wr_ptr] <= enc_inst[IBUS_DATA_WIDTH-1:0];
        mem_err[wr_ptr]  <= enc_err;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count    <= count_nxt;
      in_ready <= (count_nxt < 2'd2);
    end
  end

  // Saturating count of accepted requests that carried an error.
  always_ff @(posedge clk) begin
    if (rst)                                   err_cnt <= '0;
    else if (push && enc_err && err_cnt != '1) err_cnt <= err_cnt + 16'd1;
  end

endmodule

// File: tb/tb_ysyx_22050243_inst_encoder.sv
// Bench for the instruction encoder: directed vectors, randomized traffic against a
// field-extraction reference model and a queue scoreboard, backpressure, reset and saturation.
module tb_ysyx_22050243_inst_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_fmt = '0;
  logic [6:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [63:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic        out_err;
  logic [15:0] err_cnt;

  int checks = 0;
  int failures = 0;

  logic [32:0] q[$];   // {err, inst} expected in FIFO order
  int          mcnt = 0;

  always #5 clk = ~clk;

  ysyx_22050243_inst_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_err(out_err), .err_cnt(err_cnt)
  );

  function automatic logic [31:0] fld(input logic [63:0] v, input int hi, input int lo, input int pos);
    logic [63:0] m;
    m = (64'd1 << (hi - lo + 1)) - 64'd1;
    return 32'((v >> lo) & m) << pos;
  endfunction

  // Reference: ranges checked as signed integers, fields placed by shifting.
  function automatic logic [32:0] model(input logic [2:0] f, input logic [6:0] op,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [2:0] f3, input logic [6:0] f7, input logic [63:0] imm);
    longint s;
    logic [31:0] base, inst;
    logic err;
    s = $signed(imm);
    base = 32'(op) | (32'(f3) << 12) | (32'(rs1) << 15);
    inst = 0;
    err = 0;
    case (f)
      0: inst = base | (32'(rd) << 7) | (32'(rs2) << 20) | (32'(f7) << 25);
      1: begin inst = base | (32'(rd) << 7) | fld(imm, 11, 0, 20); err = (s < -2048 || s > 2047); end
      2: begin
        inst = base | (32'(rs2) << 20) | fld(imm, 4, 0, 7) | fld(imm, 11, 5, 25);
        err = (s < -2048 || s > 2047);
      end
      3: begin
        inst = base | (32'(rs2) << 20) | fld(imm, 11, 11, 7) | fld(imm, 4, 1, 8)
             | fld(imm, 10, 5, 25) | fld(imm, 12, 12, 31);
        err = (s < -4096 || s > 4095 || (s % 2) != 0);
      end
      4: begin
        inst = 32'(op) | (32'(rd) << 7) | fld(imm, 19, 0, 12);
        err = (s < -524288 || s > 524287);
      end
      5: begin
        inst = 32'(op) | (32'(rd) << 7) | fld(imm, 19, 12, 12) | fld(imm, 11, 11, 20)
             | fld(imm, 10, 1, 21) | fld(imm, 20, 20, 31);
        err = (s < -1048576 || s > 1048575 || (s % 2) != 0);
      end
      default: begin inst = 0; err = 1; end
    endcase
    return {err, inst};
  endfunction

  function automatic logic [32:0] cur_exp();
    return model(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
  endfunction

  // One clock: record handshakes visible now, advance, then update the scoreboard.
  task automatic tick();
    logic p, o;
    logic [32:0] e;
    p = in_valid && in_ready;
    o = out_valid && out_ready;
    e = cur_exp();
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      mcnt = 0;
    end else begin
      if (o && q.size() != 0) void'(q.pop_front());
      if (p) begin
        q.push_back(e);
        if (e[32] && mcnt < 65535) mcnt++;
      end
    end
  endtask

  task automatic rand_req();
    longint v;
    longint edges[18] = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096, -4097,
                          524287, 524288, -524288, -524289, 1048574, 1048576,
                          -1048576, -1048577, 1048575};
    in_fmt = 3'($urandom_range(0, 7));
    in_opcode = 7'($urandom);
    in_rd = 5'($urandom);
    in_rs1 = 5'($urandom);
    in_rs2 = 5'($urandom);
    in_funct3 = 3'($urandom);
    in_funct7 = 7'($urandom);
    case ($urandom_range(0, 4))
      0: v = longint'($urandom_range(0, 8191)) - 4096;
      1: v = longint'($urandom_range(0, 4194303)) - 2097152;
      2: v = edges[$urandom_range(0, 17)];
      3: v = {$urandom, $urandom};
      default: v = $urandom_range(0, 1) ? -1 : 0;
    endcase
    in_imm = v;
  endtask

  task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3, input logic [63:0] imm);
    in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = 7'h00; in_imm = imm;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_inst !== 32'h0 || out_err !== 1'b0 || err_cnt !== 16'h0) begin
      failures++;
      $display("FAIL reset: valid=%b ready=%b inst=%h err=%b cnt=%h want 0 1 0 0 0",
               out_valid, in_ready, out_inst, out_err, err_cnt);
    end
  endtask

  task automatic test_vectors();
    logic [2:0]  vf[6]   = '{1, 2, 2, 5, 3, 7};
    logic [6:0]  vop[6]  = '{7'h13, 7'h23, 7'h23, 7'h6F, 7'h63, 7'h13};
    logic [4:0]  vrd[6]  = '{1, 0, 0, 1, 0, 1};
    logic [4:0]  vrs1[6] = '{0, 1, 1, 0, 0, 0};
    logic [4:0]  vrs2[6] = '{0, 2, 2, 0, 0, 0};
    logic [2:0]  vf3[6]  = '{0, 2, 2, 0, 0, 0};
    logic [63:0] vimm[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd8, 64'd2048, 64'd2048, 64'd3, 64'd0};
    logic [31:0] xinst[6] = '{32'hFFF00093, 32'h0020A423, 32'h8020A023, 32'h001000EF, 32'h00000163, 32'h0};
    logic        xerr[6]  = '{0, 0, 1, 0, 1, 1};
    logic [15:0] xcnt[6]  = '{0, 0, 1, 1, 2, 3};
    for (int i = 0; i < 6; i++) begin
      set_req(vf[i], vop[i], vrd[i], vrs1[i], vrs2[i], vf3[i], vimm[i]);
      in_valid = 1'b1;
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_inst !== xinst[i] || out_err !== xerr[i]) begin
        failures++;
        $display("FAIL vector%0d: valid=%b inst=%h err=%b want 1 %h %b",
                 i, out_valid, out_inst, out_err, xinst[i], xerr[i]);
      end
      checks++;
      if (err_cnt !== xcnt[i]) begin
        failures++;
        $display("FAIL vector%0d_cnt: err_cnt=%0d want %0d", i, err_cnt, xcnt[i]);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rand_req();
      in_valid = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      checks++;
      if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2) || err_cnt !== 16'(mcnt)) begin
        failures++;
        $display("FAIL random_ctl cyc%0d: valid=%b ready=%b cnt=%0d want %b %b %0d",
                 n, out_valid, in_ready, err_cnt, q.size() != 0, q.size() < 2, mcnt);
      end
      if (q.size() != 0) begin
        checks++;
        if ({out_err, out_inst} !== q[0]) begin
          failures++;
          $display("FAIL random_head cyc%0d: err=%b inst=%h want err=%b inst=%h",
                   n, out_err, out_inst, q[0][32], q[0][31:0]);
        end
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 4; n++) tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [32:0] e[3];
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      rand_req();
      e[k] = cur_exp();
      tick();
    end
    rand_req();
    e[2] = cur_exp();
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_full: in_ready=%b want 0", in_ready);
    end
    tick();
    checks++;
    if (in_ready !== 1'b0 || {out_err, out_inst} !== e[0]) begin
      failures++;
      $display("FAIL bp_hold: ready=%b head=%h want 0 %h", in_ready, {out_err, out_inst}, e[0]);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_valid !== 1'b1 || {out_err, out_inst} !== e[k]) begin
        failures++;
        $display("FAIL bp_order%0d: valid=%b head=%h want 1 %h", k, out_valid, {out_err, out_inst}, e[k]);
      end
      if (k == 1) begin
        checks++;
        if (in_ready !== 1'b1) begin
          failures++;
          $display("FAIL bp_reopen: in_ready=%b want 1", in_ready);
        end
      end
      tick();
      if (k == 1) in_valid = 1'b0;
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain: out_valid=%b want 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_push_pop();
    logic [32:0] prev;
    out_ready = 1'b0;
    in_valid = 1'b1;
    rand_req();
    prev = cur_exp();
    tick();
    out_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      rand_req();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || {out_err, out_inst} !== prev) begin
        failures++;
        $display("FAIL pushpop%0d: valid=%b ready=%b head=%h want 1 1 %h",
                 n, out_valid, in_ready, {out_err, out_inst}, prev);
      end
      prev = cur_exp();
      tick();
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    set_req(3'd7, 7'h13, 5'd1, 5'd2, 5'd3, 3'd0, 64'd0);
    for (int n = 0; n < 5; n++) tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1;
    rand_req();
    tick();
    rand_req();
    tick();
    checks++;
    if (err_cnt !== 16'd5 + 16'(mcnt - 5) || out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_pre: cnt=%0d valid=%b ready=%b want %0d 1 0", err_cnt, out_valid, in_ready, mcnt);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_cnt !== 16'd0) begin
      failures++;
      $display("FAIL rstmid: valid=%b ready=%b cnt=%0d want 0 1 0", out_valid, in_ready, err_cnt);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_after: out_valid=%b want 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_saturate();
    out_ready = 1'b1;
    in_valid = 1'b1;
    set_req(3'd6, 7'h33, 5'd0, 5'd0, 5'd0, 3'd0, 64'd0);
    for (int n = 0; n < 65540; n++) begin
      tick();
      if (n % 8192 == 8191) begin
        checks++;
        if (err_cnt !== 16'(mcnt)) begin
          failures++;
          $display("FAIL sat_progress%0d: cnt=%0d want %0d", n, err_cnt, mcnt);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (err_cnt !== 16'hFFFF) begin
      failures++;
      $display("FAIL saturate: cnt=%h want ffff", err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_back_to_back();
    test_push_pop();
    test_reset_mid();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
